// File: rtl/rdma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rdma_pkg: types, constants and helpers shared by the RDMA stream blocks.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rdma_pkg;

  localparam int          RDMA_DATA_WBITS = 512;
  localparam logic [15:0] RDMA_DEST_PORT1 = 16'd4791;
  localparam logic [15:0] RDMA_DEST_PORT2 = 16'd4792;
  localparam logic [31:0] RDMA_MAGIC      = 32'h5244_4D41;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER0 = 2'd1,
    XFER1 = 2'd2
  } arb_state_t;

  // Two-way round-robin: prefer the input that was not served last, if it is valid.
  function automatic logic rdma_rr_pick(input logic v0, input logic v1, input logic last_srv);
    logic pick;
    if (last_srv) pick = v0 ? 1'b0 : 1'b1;
    else          pick = v1 ? 1'b1 : 1'b0;
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rdma_stream_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rdma_stream_arbiter: packet-atomic 2:1 round-robin AXI-Stream merge with   |
// | source tag and per-input packet counters. Revision: 1.0                    |
// +----------------------------------------------------------------------------+
module rdma_stream_arbiter
  import rdma_pkg::*;
#(
  parameter int DATA_WBITS = RDMA_DATA_WBITS,
  parameter int DATA_WBYTS = DATA_WBITS / 8,
  parameter int CNT_WBITS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [DATA_WBITS-1:0] AXIS_IN0_TDATA,
  input  logic [DATA_WBYTS-1:0] AXIS_IN0_TKEEP,
  input  logic                  AXIS_IN0_TVALID,
  input  logic                  AXIS_IN0_TLAST,
  output logic                  AXIS_IN0_TREADY,

  input  logic [DATA_WBITS-1:0] AXIS_IN1_TDATA,
  input  logic [DATA_WBYTS-1:0] AXIS_IN1_TKEEP,
  input  logic                  AXIS_IN1_TVALID,
  input  logic                  AXIS_IN1_TLAST,
  output logic                  AXIS_IN1_TREADY,

  output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
  output logic [DATA_WBYTS-1:0] AXIS_OUT_TKEEP,
  output logic                  AXIS_OUT_TVALID,
  output logic                  AXIS_OUT_TLAST,
  output logic                  AXIS_OUT_TUSER,
  input  logic                  AXIS_OUT_TREADY,

  output logic [CNT_WBITS-1:0]  PKT_COUNT0,
  output logic [CNT_WBITS-1:0]  PKT_COUNT1
);

  localparam logic [CNT_WBITS-1:0] CNT_ONE = {{(CNT_WBITS-1){1'b0}}, 1'b1};

  arb_state_t state;
  logic       last_srv;
  logic       pkt_done0;
  logic       pkt_done1;

  assign pkt_done0 = (state == XFER0) && AXIS_IN0_TVALID && AXIS_OUT_TREADY && AXIS_IN0_TLAST;
  assign pkt_done1 = (state == XFER1) && AXIS_IN1_TVALID && AXIS_OUT_TREADY && AXIS_IN1_TLAST;

  // Zero-latency datapath: the grant only steers the mux and the ready fan-back.
  always_comb begin
    AXIS_OUT_TDATA  = AXIS_IN0_TDATA;
    AXIS_OUT_TKEEP  = AXIS_IN0_TKEEP;
    AXIS_OUT_TLAST  = AXIS_IN0_TLAST;
    AXIS_OUT_TUSER  = 1'b0;
    AXIS_OUT_TVALID = 1'b0;
    AXIS_IN0_TREADY = 1'b0;
    AXIS_IN1_TREADY = 1'b0;
    case (state)
      XFER0: begin
        AXIS_OUT_TVALID = AXIS_IN0_TVALID;
        AXIS_IN0_TREADY = AXIS_OUT_TREADY;
      end
      XFER1: begin
        AXIS_OUT_TDATA  = AXIS_IN1_TDATA;
        AXIS_OUT_TKEEP  = AXIS_IN1_TKEEP;
        AXIS_OUT_TLAST  = AXIS_IN1_TLAST;
        AXIS_OUT_TUSER  = 1'b1;
        AXIS_OUT_TVALID = AXIS_IN1_TVALID;
        AXIS_IN1_TREADY = AXIS_OUT_TREADY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_srv   <= 1'b1;
      PKT_COUNT0 <= '0;
      PKT_COUNT1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (AXIS_IN0_TVALID || AXIS_IN1_TVALID)
            state <= rdma_rr_pick(AXIS_IN0_TVALID, AXIS_IN1_TVALID, last_srv) ? XFER1 : XFER0;
        end
        XFER0: begin
          // Hand over on the last beat so back-to-back packets see no bubble.
          if (pkt_done0) begin
            last_srv   <= 1'b0;
            PKT_COUNT0 <= PKT_COUNT0 + CNT_ONE;
            if (AXIS_IN1_TVALID)      state <= XFER1;
            else if (AXIS_IN0_TVALID) state <= XFER0;
            else                      state <= IDLE;
          end
        end
        XFER1: begin
          if (pkt_done1) begin
            last_srv   <= 1'b1;
            PKT_COUNT1 <= PKT_COUNT1 + CNT_ONE;
            if (AXIS_IN0_TVALID)      state <= XFER0;
            else if (AXIS_IN1_TVALID) state <= XFER1;
            else                      state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
